xy_move_sequencer: RTL
======================

# xy_move_sequencer

Coordinated two-axis move sequencer for the plotter. It accepts one line-segment command (X/Y step counts, directions, step period), then drives the X and Y step/direction outputs. The major axis steps every slot and the minor axis is interleaved by Bresenham error accumulation, so both axes finish together. It sits between the processor's motion registers and the pen-carriage step/dir pins, replacing free-running per-axis stepping with a start/busy/done handshake.

## Interface
- CNT_W, 16, width of step counts, error accumulator base width and steps_left
- PER_W, 32, width of step_period and the slot counter
- MIN_PERIOD, 2, smallest legal slot length in clocks; smaller values are clamped up to it

- clk  in  1  master clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle command request
- abort  in  1  terminate current move
- dx, dy  in  CNT_W each  step magnitudes for X and Y
- x_dir_in, y_dir_in  in  1 each  direction bits for the command
- step_period  in  PER_W  clocks per step slot
- x_step, y_step  out  1 each  step pulses to the motor drivers
- x_dir, y_dir  out  1 each  latched direction to the motor drivers
- busy  out  1  high in LOAD/HIGH/LOW
- done  out  1  one-cycle pulse at move completion or abort
- aborted  out  1  last move ended by abort
- cmd_error  out  1  sticky, set by a start rejected while busy
- steps_left  out  CNT_W  remaining major-axis slots

## Operation
- States: IDLE, LOAD, HIGH, LOW, DONE. Every output resets to 0 and the state resets to IDLE.
- start is accepted in IDLE or DONE. On acceptance, latch dx, dy, dirs and P = max(step_period, MIN_PERIOD). Clear aborted and cmd_error, then go to LOAD.
- LOAD:
  - x_dir/y_dir are updated from the latches and hold until the next accepted start. reset is the only other event that changes them.
  - Compute major = max(dx,dy); on a tie X is major. minor is the other count. Set err = major>>1. err is signed, CNT_W+1 bits.
  - Set steps_left = major.
  - If major==0, go to DONE; otherwise go to HIGH.
- Slot = HIGH for H = P>>1 clocks, then LOW for P−H clocks. Slot length is exactly P.
- At slot entry, compute err' = err − minor.
  - The major-axis step output is high for all of HIGH.
  - The minor-axis step output is high for all of HIGH only if err' < 0. In that case err ← err' + major; otherwise err ← err'.
- On the last LOW clock, decrement steps_left. If the result is 0, go to DONE; otherwise go to HIGH.
- Step outputs are low in every state except HIGH.
- DONE lasts one cycle: done=1, busy=0. It then goes to IDLE, or to LOAD if start is present.
- Across a full move, rising edges on x_step equal dx and rising edges on y_step equal dy.
- abort:
  - Sampled in LOAD/HIGH/LOW at cycle A. At A+1, step outputs are low, the state is DONE and aborted=1.
  - steps_left holds its value until the next accept.
  - abort is ignored in IDLE and DONE. If start and abort arrive together in IDLE or DONE, start is accepted.
- start while busy is ignored; cmd_error is set at the next cycle.
- step_period is sampled only at acceptance; changes mid-move have no effect.

## Timing
- start sampled at edge T: LOAD at T+1 with busy=1 and dirs valid. The first HIGH begins at T+2, so dir setup to the first step rise is 1 clock minimum.
- Slot k (0-based) begins at T+2+k·P. done is high in cycle T+2+major·P.
- major==0: done at T+2, no step pulses.
- Back-to-back: a start during DONE gives LOAD the next cycle, with no idle gap.
- All outputs are registered; no combinational path from inputs to outputs.
- reset mid-move: outputs go to 0 asynchronously, including a step that is currently high. Operation resumes from IDLE after reset deasserts.

## Test plan
- dx=4, dy=2, P=4, x_dir_in=1, y_dir_in=0, start at T -> expect:
  - 4 x_step pulses, each 2 clocks high, starting at T+2, T+6, T+10, T+14;
  - y_step pulses in slots 1 and 3 only;
  - x_dir=1 and y_dir=0 from T+1;
  - done at T+18;
  - steps_left ending at 0.
- dx=2, dy=5, P=2 -> Y is major; 5 y_step pulses and x_step in slots 1 and 3; done at T+12.
- dx=0, dy=0 -> busy only at T+1, done at T+2, no step edges.
- step_period=1 with dx=dy=3 -> P is clamped to 2; both axes pulse every slot, high 1 clock each; done at T+8.
- dx=10, P=8, abort at T+20 -> steps low at T+21, done and aborted at T+21, steps_left=8. A start at T+22 clears aborted.
- start while busy -> cmd_error=1 the next cycle while the move continues unchanged.
- reset asserted during HIGH -> x_step, y_step, busy, x_dir, y_dir and steps_left all read 0 before the next clock edge.

Source files
------------

// File: rtl/xy_move_sequencer.sv
// xy_move_sequencer
// Coordinated two-axis move sequencer for the plotter pen carriage.
// Accepts one line-segment command (X/Y step counts, directions, step period)
// and drives step/dir pins so that both axes finish together. The major axis
// steps every slot and the minor axis is interleaved by Bresenham error
// accumulation.
//
// Ports:
//   clk          master clock, all state on rising edge
//   reset        asynchronous active-high reset, clears all state
//   start        one-cycle command request (accepted in IDLE or DONE)
//   abort        terminate the current move (honoured in LOAD/HIGH/LOW)
//   dx, dy       step magnitudes for X and Y
//   x_dir_in,
//   y_dir_in     direction bits for the command
//   step_period  clocks per step slot, clamped up to MIN_PERIOD
//   x_step,
//   y_step       step pulses to the motor drivers
//   x_dir, y_dir latched directions to the motor drivers
//   busy         high in LOAD/HIGH/LOW
//   done         one-cycle pulse at move completion or abort
//   aborted      last move ended by abort
//   cmd_error    sticky, set by a start rejected while busy
//   steps_left   remaining major-axis slots
module xy_move_sequencer #(
  parameter int CNT_W      = 16,
  parameter int PER_W      = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dx,
  input  logic [CNT_W-1:0] dy,
  input  logic             x_dir_in,
  input  logic             y_dir_in,
  input  logic [PER_W-1:0] step_period,
  output logic             x_step,
  output logic             y_step,
  output logic             x_dir,
  output logic             y_dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cmd_error,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]        major_q, major_d;
  logic [CNT_W-1:0]        minor_q, minor_d;
  logic signed [CNT_W:0]   err_q, err_d;
  logic                    xMajor_q, xMajor_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic [PER_W-1:0]        half_q, half_d;
  logic [PER_W-1:0]        phaseCnt_q, phaseCnt_d;
  logic [CNT_W-1:0]        stepsLeft_q, stepsLeft_d;
  logic                    xStep_q, xStep_d;
  logic                    yStep_q, yStep_d;
  logic                    xDir_q, xDir_d;
  logic                    yDir_q, yDir_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    cmdError_q, cmdError_d;

  // Command decode used at acceptance: clamped period and major/minor split
  // (a tie makes X the major axis).
  logic [PER_W-1:0]        periodClamped;
  logic                    dxGeDy;
  logic [CNT_W-1:0]        newMajor;
  logic [CNT_W-1:0]        newMinor;

  // Bresenham step for the slot about to begin. The sign bit of the trial
  // error decides whether the minor axis steps in this slot.
  logic signed [CNT_W:0]   minorExt;
  logic signed [CNT_W:0]   majorExt;
  logic signed [CNT_W:0]   errTrial;
  logic signed [CNT_W:0]   errAfter;
  logic                    minorFire;
  logic [CNT_W-1:0]        stepsDec;

  assign periodClamped = (step_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : step_period;
  assign dxGeDy        = (dx >= dy);
  assign newMajor      = dxGeDy ? dx : dy;
  assign newMinor      = dxGeDy ? dy : dx;

  assign minorExt  = $signed({1'b0, minor_q});
  assign majorExt  = $signed({1'b0, major_q});
  assign errTrial  = err_q - minorExt;
  assign minorFire = errTrial[CNT_W];
  assign errAfter  = minorFire ? (errTrial + majorExt) : errTrial;
  assign stepsDec  = stepsLeft_q - CNT_W'(1);

  // State and output register bank; every output is a flop so nothing
  // combinational reaches the motor pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      major_q     <= '0;
      minor_q     <= '0;
      err_q       <= '0;
      xMajor_q    <= 1'b0;
      period_q    <= '0;
      half_q      <= '0;
      phaseCnt_q  <= '0;
      stepsLeft_q <= '0;
      xStep_q     <= 1'b0;
      yStep_q     <= 1'b0;
      xDir_q      <= 1'b0;
      yDir_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmdError_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      major_q     <= major_d;
      minor_q     <= minor_d;
      err_q       <= err_d;
      xMajor_q    <= xMajor_d;
      period_q    <= period_d;
      half_q      <= half_d;
      phaseCnt_q  <= phaseCnt_d;
      stepsLeft_q <= stepsLeft_d;
      xStep_q     <= xStep_d;
      yStep_q     <= yStep_d;
      xDir_q      <= xDir_d;
      yDir_q      <= yDir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cmdError_q  <= cmdError_d;
    end
  end

  // Next-state logic. The LOAD work (dirs, major/minor, initial error,
  // steps_left) is captured on the accepting edge so it is visible during
  // the LOAD cycle itself. phaseCnt counts down the clocks left in the
  // current HIGH or LOW phase; slot entry loads it and fixes the step levels
  // that then hold for the whole HIGH phase.
  always_comb begin
    logic enterSlot;
    enterSlot   = 1'b0;
    state_d     = state_q;
    major_d     = major_q;
    minor_d     = minor_q;
    err_d       = err_q;
    xMajor_d    = xMajor_q;
    period_d    = period_q;
    half_d      = half_q;
    phaseCnt_d  = phaseCnt_q;
    stepsLeft_d = stepsLeft_q;
    xStep_d     = 1'b0;
    yStep_d     = 1'b0;
    xDir_d      = xDir_q;
    yDir_d      = yDir_q;
    aborted_d   = aborted_q;
    cmdError_d  = cmdError_q;

    // A start while a move is in progress is refused but remembered.
    if (start && (state_q == LOAD || state_q == HIGH || state_q == LOW)) begin
      cmdError_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          xDir_d      = x_dir_in;
          yDir_d      = y_dir_in;
          major_d     = newMajor;
          minor_d     = newMinor;
          xMajor_d    = dxGeDy;
          err_d       = $signed({2'b00, newMajor[CNT_W-1:1]});
          period_d    = periodClamped;
          half_d      = periodClamped >> 1;
          stepsLeft_d = newMajor;
          aborted_d   = 1'b0;
          cmdError_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (major_q == '0) begin
          state_d = DONE;
        end else begin
          enterSlot = 1'b1;
        end
      end
      HIGH: begin
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (phaseCnt_q == '0) begin
          state_d    = LOW;
          phaseCnt_d = period_q - half_q - PER_W'(1);
        end else begin
          phaseCnt_d = phaseCnt_q - PER_W'(1);
          xStep_d    = xStep_q;
          yStep_d    = yStep_q;
        end
      end
      LOW: begin
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (phaseCnt_q == '0) begin
          stepsLeft_d = stepsDec;
          if (stepsDec == '0) begin
            state_d = DONE;
          end else begin
            enterSlot = 1'b1;
          end
        end else begin
          phaseCnt_d = phaseCnt_q - PER_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enterSlot) begin
      state_d    = HIGH;
      phaseCnt_d = half_q - PER_W'(1);
      err_d      = errAfter;
      xStep_d    = xMajor_q ? 1'b1 : minorFire;
      yStep_d    = xMajor_q ? minorFire : 1'b1;
    end

    done_d = (state_d == DONE);
    busy_d = (state_d == LOAD) || (state_d == HIGH) || (state_d == LOW);
  end

  assign x_step     = xStep_q;
  assign y_step     = yStep_q;
  assign x_dir      = xDir_q;
  assign y_dir      = yDir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign cmd_error  = cmdError_q;
  assign steps_left = stepsLeft_q;

endmodule
